apa102_out: RTL
===============

# apa102_out

Transmit-side APA102 serial driver. On a start pulse, latches a 7-LED payload vector and shifts out a complete APA102 frame on sck/sda: a 32-bit all-zero start frame, NUM_LEDS 32-bit LED frames MSB-first, then a 32-bit all-ones end frame. sck is derived from the system clock by a fixed divider. The block drives an LED chain, or a downstream APA102 receiver, from on-chip pattern logic.

## Interface
- CLK_DIV, default 2: system clocks per sck half-period; legal range 1..255.
- NUM_LEDS, default 7: LED frames per transfer; payload width is 32*NUM_LEDS.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled each clk edge.
- data_in  input  32*NUM_LEDS  payload; bit [32*NUM_LEDS-1] is sent first (LED0 brightness byte MSB).
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- sck  output  1  serial clock; idles low.
- sda  output  1  serial data; changes only while sck is low.

## Operation
- States: IDLE, START_FR, DATA, END_FR.
- IDLE: if start=1 at a clk edge, latch data_in into the shift register, clear the bit counter, set busy=1, sck=0, drive sda with start-frame bit 0 (value 0), and enter START_FR. While busy=1, start is ignored and data_in is not sampled.
- Every bit has a low phase of CLK_DIV clocks followed by a high phase of CLK_DIV clocks. sda updates at the same edge where sck falls (start of the low phase). The receiver samples on the sck rising edge, so sda is stable for CLK_DIV clocks before and after that edge.
- START_FR: 32 bits of 0. After bit 31, go to DATA.
- DATA: 32*NUM_LEDS bits shifted out MSB-first from the latched register. Contents pass through unmodified, including the 3'b111 header and brightness bits. After the last bit, go to END_FR.
- END_FR: 32 bits of 1. The falling edge after bit 31 completes the transfer: sck=0, sda=0, busy=0, done=1 for one cycle, state goes to IDLE.
- Bit counter width: at least 9 bits for NUM_LEDS=7. Total bits per transfer = 32*(NUM_LEDS+2) = 288 by default.
- Reset, asynchronous and valid at any time including mid-frame: state=IDLE, sck=0, sda=0, busy=0, done=0, shift register and counters cleared. A truncated frame is not resumed. Downstream receivers resynchronise on the next 32-zero start frame.

## Timing
- Take T as the edge at which start is accepted.
- busy rises at T, and sda holds bit 0 from T.
- The first sck rise is at T+CLK_DIV. Bit k rises at T+(2k+1)*CLK_DIV and falls at T+(2k+2)*CLK_DIV.
- done pulses and busy falls at T+2*CLK_DIV*288, i.e. T+1152 for CLK_DIV=2.
- done and busy=0 coincide on the same cycle. A start held high during that cycle is not accepted there, because busy was still high at the sampling edge. It is accepted one cycle later, so back-to-back transfers have a minimum one-cycle idle gap with sck low.
- Exactly 288 sck rising edges per transfer. No sck glitches, and sck is low throughout IDLE.
- sda never changes while sck=1.

## Test plan
- Single transfer, CLK_DIV=2, data_in = {32'hE1FF0000, 32'hE200FF00, 32'hE30000FF, 32'hFF123456, 32'hE0000000, 32'hFFFFFFFF, 32'hEA5A5A5A}, one-cycle start -> bit-sampler on sck rise captures 32 zeros, the 224 payload bits in order, then 32 ones. Check 288 rising edges, and done at exactly T+1152 with busy high from T to T+1151.
- start held high continuously, and data_in changed mid-transfer -> the transfer carries the payload latched at T. The next transfer starts one cycle after done and carries the new data_in. The second sck rise does not begin before the gap.
- CLK_DIV=1 -> sck toggles every clk, 576 cycles of busy, same captured bitstream.
- Assert rst at T+300 (mid DATA) for one cycle -> sck, sda, busy and done are all 0 immediately, without waiting for a clk edge. A following start produces a complete, correct 288-bit frame.
- Protocol monitor over all runs -> sda is never seen changing while sck=1, done is always a single cycle, and start pulses while busy=1 produce no extra frames.

Source files
------------

// File: rtl/apa102_out.sv
// APA102 serial transmitter: start frame of 32 zeros, NUM_LEDS 32-bit LED frames
// MSB-first, then an end frame of 32 ones, with sck derived by a fixed divider.
module apa102_out #(
  parameter int CLK_DIV  = 2,
  parameter int NUM_LEDS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [32*NUM_LEDS-1:0]   data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     sck,
  output logic                     sda
);

  localparam int DATA_BITS  = 32 * NUM_LEDS;
  localparam int TOTAL_BITS = DATA_BITS + 64;
  localparam int CNT_W      = $clog2(TOTAL_BITS);
  localparam int DIV_W      = 8;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(31 + DATA_BITS);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(TOTAL_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START_FR, DATA, END_FR} state_t;

  state_t                 state_reg,  state_next;
  logic [DIV_W-1:0]       div_reg,    div_next;
  logic [CNT_W-1:0]       bit_reg,    bit_next;
  logic [DATA_BITS-1:0]   shift_reg,  shift_next;
  logic                   sck_reg,    sck_next;
  logic                   sda_reg,    sda_next;
  logic                   busy_reg,   busy_next;
  logic                   done_reg,   done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      sck_reg   <= 1'b0;
      sda_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      sck_reg   <= sck_next;
      sda_reg   <= sda_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    sck_next   = sck_reg;
    sda_next   = sda_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (state_reg == IDLE) begin
      if (start) begin
        shift_next = data_in;
        bit_next   = '0;
        div_next   = '0;
        busy_next  = 1'b1;
        sck_next   = 1'b0;
        sda_next   = 1'b0;
        state_next = START_FR;
      end
    end else if (div_reg != DIV_LAST) begin
      div_next = div_reg + 1'b1;
    end else begin
      div_next = '0;
      if (!sck_reg) begin
        sck_next = 1'b1;
      end else begin
        // Falling edge: finish the current bit and present the next one on sda.
        sck_next = 1'b0;
        bit_next = bit_reg + 1'b1;
        if (state_reg == START_FR) begin
          if (bit_reg == START_LAST) begin
            state_next = DATA;
            sda_next   = shift_reg[DATA_BITS-1];
            shift_next = {shift_reg[DATA_BITS-2:0], 1'b0};
          end
        end else if (state_reg == DATA) begin
          if (bit_reg == DATA_LAST) begin
            state_next = END_FR;
            sda_next   = 1'b1;
          end else begin
            sda_next   = shift_reg[DATA_BITS-1];
            shift_next = {shift_reg[DATA_BITS-2:0], 1'b0};
          end
        end else if (bit_reg == END_LAST) begin
          state_next = IDLE;
          sda_next   = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          bit_next   = '0;
        end
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sck  = sck_reg;
  assign sda  = sda_reg;

endmodule
